// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the FSM state encoding, the line idle level and the frame-length calculation.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  localparam logic IDLE_LVL = 1'b1;

  // Baud periods in one frame: start + data + optional parity + stop bits.
  function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter producing a one-hot grant in the same cycle (combinational).
// On a tie, the client that did not win last time is granted; with enable low, nothing is granted.
module uart_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates two byte clients and serialises the granted byte onto txd, paced by clk_bps.
// A ready is given only in IDLE; requests arriving during a frame are held until it ends.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              bps_start,
  input  logic              clk_bps,
  output logic              txd,
  output logic              busy,
  output logic              grant_id,
  output logic              tx_done
);

  localparam int FRAME = frame_len(DATA_W, PARITY_EN, STOP_BITS);
  localparam int CNT_W = $clog2(FRAME + 2);

  localparam logic [CNT_W-1:0] POS_START     = CNT_W'(1);
  localparam logic [CNT_W-1:0] POS_LAST_DATA = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] POS_PARITY    = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0] POS_END       = CNT_W'(FRAME + 1);

  tx_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [DATA_W-1:0]  shreg;
  logic               par_bit;
  logic               last_grant;
  logic [1:0]         grant;
  logic               arb_en;
  logic [DATA_W-1:0]  sel_data;

  // Readys are held low while reset is asserted so nothing is accepted then.
  assign arb_en = rst_n && (state == ST_IDLE);

  uart_rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign cnt_nxt    = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      txd        <= IDLE_LVL;
      busy       <= 1'b0;
      bps_start  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            shreg      <= sel_data;
            par_bit    <= ^sel_data;
            grant_id   <= grant[1];
            last_grant <= grant[1];
            busy       <= 1'b1;
            bps_start  <= 1'b1;
            cnt        <= '0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (clk_bps) begin
            cnt <= cnt_nxt;
            // The final tick closes the last stop-bit period rather than starting a new bit.
            if (cnt_nxt == POS_END) begin
              txd       <= IDLE_LVL;
              bps_start <= 1'b0;
              busy      <= 1'b0;
              tx_done   <= 1'b1;
              state     <= ST_IDLE;
            end else if (cnt_nxt == POS_START) begin
              txd <= 1'b0;
            end else if (cnt_nxt <= POS_LAST_DATA) begin
              txd   <= shreg[0];
              shreg <= shreg >> 1;
            end else if ((PARITY_EN != 0) && (cnt_nxt == POS_PARITY)) begin
              txd <= par_bit;
            end else begin
              txd <= IDLE_LVL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench: three scheduler instances (default, parity, two stop bits) share one clock/reset.
// A scaled-down baud model drives clk_bps; a monitor rebuilds each frame from txd and checks it.
module tb_uart_tx_sched;

  localparam int BAUD_DIV = 16;

  typedef struct {
    logic [7:0] data;
    logic       gid;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data [3];
  logic [7:0] req1_data [3];
  logic [2:0] bps_start, clk_bps, txd, busy, grant_id, tx_done;
  logic [2:0] bpulse, inj, pend;
  int         bcnt [3];
  int         pidx [3];
  int         rdy_cnt [3];
  logic [15:0] fbits [3];
  logic [15:0] last_bits [3];
  exp_t       sb_q [3][$];
  int         n_total = 0;
  int         n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_sched #(
      .DATA_W    (8),
      .PARITY_EN ((g == 1) ? 1 : 0),
      .STOP_BITS ((g == 2) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid[g]),
      .req0_data  (req0_data[g]),
      .req0_ready (req0_ready[g]),
      .req1_valid (req1_valid[g]),
      .req1_data  (req1_data[g]),
      .req1_ready (req1_ready[g]),
      .bps_start  (bps_start[g]),
      .clk_bps    (clk_bps[g]),
      .txd        (txd[g]),
      .busy       (busy[g]),
      .grant_id   (grant_id[g]),
      .tx_done    (tx_done[g])
    );
  end

  assign clk_bps = bpulse | inj;

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int stop_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Baud generator: first tick half a period after bps_start rises, then one per period.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!bps_start[i]) begin
        bcnt[i]   <= 0;
        bpulse[i] <= 1'b0;
      end else begin
        bcnt[i]   <= bcnt[i] + 1;
        bpulse[i] <= ((bcnt[i] % BAUD_DIV) == (BAUD_DIV / 2 - 1));
      end
    end
  end

  task automatic finish_frame(input int i);
    exp_t e;
    logic [7:0] d;
    int ones;
    int frm;
    frm = 1 + 8 + par_of(i) + stop_of(i);
    check_eq($sformatf("sb_has_entry%0d", i), sb_q[i].size() > 0, 1);
    if (sb_q[i].size() > 0) begin
      e = sb_q[i].pop_front();
      check_eq($sformatf("done_pulse%0d", i), pidx[i], frm + 1);
      check_eq($sformatf("start_bit%0d", i), fbits[i][1], 1'b0);
      for (int k = 0; k < 8; k++) d[k] = fbits[i][2 + k];
      check_eq($sformatf("data%0d", i), d, e.data);
      if (par_of(i) != 0) check_eq($sformatf("parity%0d", i), fbits[i][10], ^e.data);
      ones = 0;
      for (int k = 2 + 8 + par_of(i); k <= frm + 1; k++) ones += fbits[i][k];
      check_eq($sformatf("stop_bits%0d", i), ones, stop_of(i) + 1);
      check_eq($sformatf("grant_id%0d", i), grant_id[i], e.gid);
    end
  endtask

  // Frame monitor: records txd after every tick consumed during a frame.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        pidx[i]  = 0;
        pend[i]  = 1'b0;
        fbits[i] = '0;
      end else begin
        rdy_cnt[i] = rdy_cnt[i] + int'(req0_ready[i]) + int'(req1_ready[i]);
        if (pend[i]) begin
          pidx[i]++;
          if (pidx[i] < 16) fbits[i][pidx[i]] = txd[i];
        end
        pend[i] = clk_bps[i] && busy[i];
        if (tx_done[i]) begin
          finish_frame(i);
          last_bits[i] = fbits[i];
          fbits[i] = '0;
          pidx[i] = 0;
        end
      end
    end
  end

  task automatic wait_ready(input int i, input int c, input string tag);
    int n;
    n = 0;
    #1;
    while (!((c == 0) ? req0_ready[i] : req1_ready[i]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (c == 0) ? req0_ready[i] : req1_ready[i], 1'b1);
  endtask

  task automatic wait_idle(input int i, input string tag);
    int n;
    n = 0;
    while ((sb_q[i].size() != 0 || busy[i]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, sb_q[i].size(), 0);
  endtask

  task automatic push_exp(input int i, input logic [7:0] d, input logic gid);
    exp_t e;
    e.data = d;
    e.gid  = gid;
    sb_q[i].push_back(e);
  endtask

  task automatic send(input int i, input int c, input logic [7:0] d, input string tag);
    push_exp(i, d, c[0]);
    if (c == 0) begin req0_data[i] = d; req0_valid[i] = 1'b1; end
    else        begin req1_data[i] = d; req1_valid[i] = 1'b1; end
    wait_ready(i, c, tag);
    @(posedge clk); #1;
    if (c == 0) req0_valid[i] = 1'b0;
    else        req1_valid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req0_valid = '0;
    req1_valid = '0;
    inj = '0;
    for (int i = 0; i < 3; i++) begin
      req0_data[i] = '0;
      req1_data[i] = '0;
      rdy_cnt[i]   = 0;
      last_bits[i] = '0;
    end
    // Client 0 of instance 0 is already requesting while reset is held.
    req0_data[0]  = 8'h55;
    req0_valid[0] = 1'b1;
    push_exp(0, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_outs%0d", i), {txd[i], bps_start[i], busy[i], tx_done[i], grant_id[i]}, 5'b10000);
      check_eq($sformatf("rst_rdy%0d", i), {req1_ready[i], req0_ready[i]}, 2'b00);
    end
    #1 rst_n = 1'b1;

    // 0x55 frame, ready for exactly one cycle even with valid held into the frame
    wait_ready(0, 0, "t1_rdy");
    @(posedge clk); #1;
    check_eq("t1_busy", busy[0], 1'b1);
    repeat (3) @(posedge clk);
    #1 req0_valid[0] = 1'b0;
    wait_idle(0, "t1_drain");
    check_eq("t1_rdy_cycles", rdy_cnt[0], 1);
    check_eq("t1_wave", last_bits[0][10:1], 10'b1010101010);

    // Ticks while idle must be ignored
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 inj[0] = 1'b1;
      @(posedge clk); #1 inj[0] = 1'b0;
      @(negedge clk);
      check_eq("t5_idle", {txd[0], busy[0], tx_done[0], bps_start[0], req0_ready[0], req1_ready[0]}, 6'b100000);
    end

    // Tie after reset: client 0 first, then alternate
    req0_data[0] = 8'hA0; req0_valid[0] = 1'b1;
    req1_data[0] = 8'h0B; req1_valid[0] = 1'b1;
    push_exp(0, 8'hA0, 1'b0);
    push_exp(0, 8'h0B, 1'b1);
    push_exp(0, 8'h3C, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("t2_rst_gate", {req1_ready[0], req0_ready[0]}, 2'b00);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_ready(0, 0, "t2_a0");
    check_eq("t2_one_hot", req1_ready[0], 1'b0);
    @(posedge clk); #1 req0_data[0] = 8'h3C;
    wait_ready(0, 1, "t2_0b");
    @(posedge clk); #1 req1_valid[0] = 1'b0;
    wait_ready(0, 0, "t2_3c");
    @(posedge clk); #1 req0_valid[0] = 1'b0;
    wait_idle(0, "t2_drain");

    // Reset in the middle of an 0xFF frame, with client 1 waiting
    send(0, 0, 8'hFF, "t4_ff");
    req1_data[0] = 8'h5A; req1_valid[0] = 1'b1;
    n = 0;
    while (pidx[0] < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_reach_p4", pidx[0], 4);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_async", {txd[0], bps_start[0], busy[0], req1_ready[0]}, 4'b1000);
    void'(sb_q[0].pop_front());
    push_exp(0, 8'h5A, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ready(0, 1, "t4_regrant");
    @(posedge clk); #1 req1_valid[0] = 1'b0;
    wait_idle(0, "t4_drain");

    // Even parity
    send(1, 0, 8'h07, "t3_07");
    wait_idle(1, "t3_drain07");
    send(1, 1, 8'h03, "t3_03");
    wait_idle(1, "t3_drain03");

    // Two stop bits, then a held request granted right after tx_done
    send(2, 0, 8'h00, "t6_00");
    req1_data[2] = 8'h81; req1_valid[2] = 1'b1;
    push_exp(2, 8'h81, 1'b1);
    n = 0;
    while (!tx_done[2] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_done_seen", tx_done[2], 1'b1);
    check_eq("t6_b2b", req1_ready[2], 1'b1);
    @(posedge clk); #1;
    req1_valid[2] = 1'b0;
    check_eq("t6_b2b_busy", busy[2], 1'b1);
    wait_idle(2, "t6_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
